// File: rtl/osd_text_loader.sv
// osd_text_loader
//   Character-cell front end for the OSD overlay. Holds a 2 x 16 ASCII text
//   buffer, expands it through an external 8x16 font ROM into a shadow bitmap
//   (32 rows x 128 pixels), and commits the shadow to char_bits on a vsync
//   active edge so the overlay never shows a half-built frame.
//
// Ports
//   pclk, rst_n          pixel clock, async active-low reset
//   txt_wr_en/addr/data  text buffer write port; addr[4] = line, addr[3:0] = column
//   i_vs                 video vsync, active level set by VS_POL
//   font_rom_rd_en/addr  font ROM read request, addr = {code, glyph_row}
//   font_rom_data        glyph row returned one cycle after the request, MSB = leftmost
//   char_bits            committed bitmap; pixel x of row r is bit r*128+127-x
//   busy                 high while a frame is being built or awaiting commit
//   frame_updated        one-cycle pulse, high in the same cycle char_bits changes
//
// state  | meaning
// IDLE   | buffer clean, waiting for a write
// BUILD  | 512 ROM reads, one per {cell, glyph_row}
// DRAIN  | capture the last ROM word
// PEND   | shadow complete, waiting for the vsync active edge
// COMMIT | char_bits holds the new frame, frame_updated pulses

module osd_text_loader #(
    parameter bit VS_POL  = 1'b1,
    parameter int ROM_LAT = 1
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          txt_wr_en,
    input  logic [4:0]    txt_wr_addr,
    input  logic [7:0]    txt_wr_data,
    input  logic          i_vs,
    output logic          font_rom_rd_en,
    output logic [11:0]   font_rom_addr,
    input  logic [7:0]    font_rom_data,
    output logic [4095:0] char_bits,
    output logic          busy,
    output logic          frame_updated
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUILD  = 3'd1,
        DRAIN  = 3'd2,
        PEND   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    // Only a single-cycle ROM is supported; any other latency never captures.
    localparam bit LAT_OK = (ROM_LAT == 1);

    state_t          state, state_nxt;
    logic [7:0]      txt_buf [32];
    logic            dirty;
    logic [8:0]      idx;
    logic            cap_vld;
    logic [8:0]      cap_idx;
    logic [4095:0]   shadow;
    logic            vs_q, vs_qq;
    logic            vs_edge;
    logic [4:0]      cap_row;
    logic [3:0]      cap_col;
    logic [11:0]     cap_base;

    assign vs_edge = (vs_q == VS_POL) && (vs_qq != VS_POL);

    // idx = {cell[4:0], glyph_row[3:0]}; bitmap row is {line, glyph_row}
    assign cap_row  = {cap_idx[8], cap_idx[3:0]};
    assign cap_col  = cap_idx[7:4];
    assign cap_base = {cap_row, 7'h7f} - {5'd0, cap_col, 3'd0};

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        font_rom_rd_en = 1'b0;
        font_rom_addr  = 12'd0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (dirty) state_nxt = BUILD;
            end
            BUILD: begin
                busy           = 1'b1;
                font_rom_rd_en = 1'b1;
                font_rom_addr  = {txt_buf[idx[8:4]], idx[3:0]};
                if (idx == 9'd511) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = PEND;
            end
            PEND: begin
                busy = 1'b1;
                if (vs_edge) state_nxt = COMMIT;
            end
            COMMIT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) txt_buf[i] <= 8'h20;
            dirty         <= 1'b1;
            idx           <= 9'd0;
            cap_vld       <= 1'b0;
            cap_idx       <= 9'd0;
            shadow        <= '0;
            char_bits     <= '0;
            frame_updated <= 1'b0;
            vs_q          <= ~VS_POL;
            vs_qq         <= ~VS_POL;
        end else begin
            vs_q  <= i_vs;
            vs_qq <= vs_q;

            if (state == IDLE && dirty) dirty <= 1'b0;
            // A write landing on the same edge as the clear still wins, so it
            // can never be lost between two builds.
            if (txt_wr_en) begin
                txt_buf[txt_wr_addr] <= txt_wr_data;
                dirty                <= 1'b1;
            end

            if (state == IDLE) idx <= 9'd0;
            else if (state == BUILD) idx <= idx + 9'd1;

            cap_vld <= font_rom_rd_en;
            cap_idx <= idx;
            if (LAT_OK && cap_vld) shadow[cap_base -: 8] <= font_rom_data;

            // char_bits and frame_updated switch together on entry to COMMIT
            frame_updated <= (state == PEND) && vs_edge;
            if (state == PEND && vs_edge) char_bits <= shadow;
        end
    end

endmodule
